// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: gfedcba glyph table (active-high) and anode encodings.
// Both the display driver and the scan decoder draw from this one table.
package seg7_pkg;

    localparam logic [1:0] AN_ONES  = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;
    localparam logic [1:0] AN_BLANK = 2'b11;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// Combinational reverse lookup: active-high gfedcba pattern to hex nibble.
// valid_o is low for any pattern that is not one of the 16 glyphs.
module seg7_pattern_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       valid_o
);

    always_comb begin
        nibble_o = 4'h0;
        valid_o  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == hex_to_seg(4'(i))) begin
                nibble_o = 4'(i);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Receive-side decoder for a two-digit multiplexed 7-segment bus: waits for each
// digit slot to settle, decodes it and publishes the reassembled {tens, ones} score.
module seven_seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic [1:0] an,
    output logic [7:0] score,
    output logic       score_valid,
    output logic       frame_err,
    output logic       stale
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYCLES);
    localparam logic [SCW-1:0] STAB_PRE = SCW'(STABLE_CYCLES - 1);
    localparam logic [TOW-1:0] TMO_MAX  = TOW'(TIMEOUT_CYCLES);

    logic [6:0]     seg_s1_q, seg_s2_q;
    logic [1:0]     an_s1_q, an_s2_q;
    logic [8:0]     prev_q;
    logic [SCW-1:0] stab_q, stab_d;
    logic [3:0]     ones_q, ones_d, tens_q, tens_d;
    logic           have_ones_q, have_ones_d, have_tens_q, have_tens_d;
    logic [7:0]     score_q, score_d;
    logic           valid_q, valid_d, err_q, err_d;
    logic [TOW-1:0] tmo_q, tmo_d;

    logic [8:0] sample;
    logic       same, capture, publish, pat_ok;
    logic [6:0] pattern;
    logic [3:0] nibble;

    assign sample  = {an_s2_q, seg_s2_q};
    assign same    = (sample == prev_q);
    assign capture = same && (stab_q == STAB_PRE);
    assign publish = have_ones_q && have_tens_q;
    assign pattern = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;

    seg7_pattern_to_hex u_dec (
        .pattern_i (pattern),
        .nibble_o  (nibble),
        .valid_o   (pat_ok)
    );

    always_comb begin
        stab_d      = same ? ((stab_q == STAB_MAX) ? STAB_MAX : stab_q + 1'b1) : SCW'(1);
        ones_d      = ones_q;
        tens_d      = tens_q;
        have_ones_d = have_ones_q;
        have_tens_d = have_tens_q;
        score_d     = score_q;
        valid_d     = publish;
        err_d       = 1'b0;
        // Publish clears the flags first so a capture in the same cycle opens the next frame.
        if (publish) begin
            score_d     = {tens_q, ones_q};
            have_ones_d = 1'b0;
            have_tens_d = 1'b0;
        end
        if (capture) begin
            case (an_s2_q)
                AN_ONES: begin
                    if (pat_ok) begin
                        ones_d      = nibble;
                        have_ones_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                AN_TENS: begin
                    if (pat_ok) begin
                        tens_d      = nibble;
                        have_tens_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                AN_BLANK: ;
                default: err_d = 1'b1;
            endcase
        end
        if (err_d) begin
            have_ones_d = 1'b0;
            have_tens_d = 1'b0;
        end
        // The score_valid cycle counts as the first idle cycle, so stale drops right after it.
        if (valid_q) begin
            tmo_d = TOW'(1);
        end else begin
            tmo_d = (tmo_q == TMO_MAX) ? TMO_MAX : tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q    <= '0;
            seg_s2_q    <= '0;
            an_s1_q     <= '0;
            an_s2_q     <= '0;
            prev_q      <= '0;
            stab_q      <= '0;
            ones_q      <= '0;
            tens_q      <= '0;
            have_ones_q <= 1'b0;
            have_tens_q <= 1'b0;
            score_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= TMO_MAX;
        end else begin
            seg_s1_q    <= seg;
            seg_s2_q    <= seg_s1_q;
            an_s1_q     <= an;
            an_s2_q     <= an_s1_q;
            prev_q      <= sample;
            stab_q      <= stab_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            have_ones_q <= have_ones_d;
            have_tens_q <= have_tens_d;
            score_q     <= score_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign score       = score_q;
    assign score_valid = valid_q;
    assign frame_err   = err_q;
    assign stale       = (tmo_q == TMO_MAX);

endmodule
